ysyx_22040632_clint: RTL and testbench

Core-local interruptor serving the MEM stage over the `mem2clint` port. It holds the `msip`, `mtimecmp` and free-running `mtime` registers. It answers MEM's CLINT-window loads and stores and drives the machine timer and software interrupt lines toward the CSR/trap logic. Registers are 64-bit and memory-mapped at a fixed base; accesses are single-beat with no handshake.

---
 rtl/ysyx_22040632_clint_pkg.sv | 48 ++++
 rtl/ysyx_22040632_clint_tick.sv | 41 ++++
 rtl/ysyx_22040632_clint.sv | 107 ++++++++++
 tb/tb_ysyx_22040632_clint.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040632_clint_pkg.sv
// ysyx_22040632_clint_pkg
// Shared constants for the core-local interruptor and for MEM's address decode.
// Holds the register offsets inside the CLINT window, the mtimecmp reset value,
// the register-select enum and the window decode helper.
// Ports: none (package).

`timescale 1ns/1ps

package ysyx_22040632_clint_pkg;

    localparam logic [31:0] CLINT_MSIP_OFF     = 32'h0000_0000;
    localparam logic [31:0] CLINT_MTIMECMP_OFF = 32'h0000_4000;
    localparam logic [31:0] CLINT_MTIME_OFF    = 32'h0000_BFF8;

    // All ones keeps mtip low out of reset, since mtime starts at zero.
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_MTIMECMP,
        SEL_MTIME
    } clint_sel_e;

    // Decode works on the 8-byte word address only, so the byte offset within a
    // register never matters. Anything that is not one of the three registers,
    // inside or outside the window, decodes to SEL_NONE.
    function automatic clint_sel_e clint_decode(input logic [28:0] word_addr,
                                                input logic [31:0] base);
        logic [31:0] msip_addr;
        logic [31:0] mtimecmp_addr;
        logic [31:0] mtime_addr;
        clint_sel_e  sel;
        msip_addr     = base + CLINT_MSIP_OFF;
        mtimecmp_addr = base + CLINT_MTIMECMP_OFF;
        mtime_addr    = base + CLINT_MTIME_OFF;
        sel           = SEL_NONE;
        if (word_addr == msip_addr[31:3]) begin
            sel = SEL_MSIP;
        end else if (word_addr == mtimecmp_addr[31:3]) begin
            sel = SEL_MTIMECMP;
        end else if (word_addr == mtime_addr[31:3]) begin
            sel = SEL_MTIME;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ysyx_22040632_clint_tick.sv
// ysyx_22040632_clint_tick
// Prescaler for mtime: raises tick once every TICK_DIV core cycles.
// Ports:
//   clk   - core clock
//   rst_n - synchronous active-low reset, discards any partial count
//   tick  - high in the cycle the counter sits at TICK_DIV-1

`timescale 1ns/1ps

module ysyx_22040632_clint_tick
    import ysyx_22040632_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [15:0] LAST_CNT = 16'(TICK_DIV - 1);

    logic [15:0] tick_cnt_q;
    logic [15:0] tick_cnt_d;

    // The counter wraps to zero in the same cycle tick is raised, so with
    // TICK_DIV of one the counter never leaves zero and tick is always high.
    always_comb begin
        tick       = (tick_cnt_q == LAST_CNT);
        tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
    end

    // Counter register; reset restarts the count from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q <= 16'd0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_22040632_clint.sv
// ysyx_22040632_clint
// Core-local interruptor for the MEM stage: msip, mtimecmp and mtime registers,
// single-beat load/store access, and the timer/software interrupt lines.
// Ports:
//   clk              - core clock
//   rst_n            - synchronous active-low reset
//   wen_clint        - one-cycle store strobe from MEM
//   addr_clint       - byte address, shared by loads and stores
//   data_write_clint - 64-bit store data
//   data_read_clint  - 64-bit load data, combinational from addr_clint
//   mtip_o           - registered mtime >= mtimecmp
//   msip_o           - msip bit 0 flop

`timescale 1ns/1ps

module ysyx_22040632_clint
    import ysyx_22040632_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1,
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wen_clint,
    input  logic [31:0] addr_clint,
    input  logic [63:0] data_write_clint,
    output logic [63:0] data_read_clint,
    output logic        mtip_o,
    output logic        msip_o
);

    logic        tick;
    clint_sel_e  sel;
    logic [63:0] mtime_q;
    logic [63:0] mtime_d;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtimecmp_d;
    logic        msip_q;
    logic        msip_d;
    logic        mtip_q;
    logic        mtip_d;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr_clint[2:0];

    ysyx_22040632_clint_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Next-state for the register file. A store to mtime takes priority over
    // the prescaler tick, so a tick in the same cycle as the store is lost.
    // The compare uses the current register values, which puts mtip one edge
    // behind any register change.
    always_comb begin
        sel        = clint_decode(addr_clint[31:3], CLINT_BASE);
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        mtip_d     = (mtime_q >= mtimecmp_q);
        if (wen_clint && (sel == SEL_MTIME)) begin
            mtime_d = data_write_clint;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wen_clint && (sel == SEL_MTIMECMP)) begin
            mtimecmp_d = data_write_clint;
        end
        if (wen_clint && (sel == SEL_MSIP)) begin
            msip_d = data_write_clint[0];
        end
    end

    // Load path reads the registers as they stand, so a same-cycle store is
    // not forwarded and unmapped addresses read back zero.
    always_comb begin
        data_read_clint = 64'd0;
        case (sel)
            SEL_MSIP:     data_read_clint = {63'd0, msip_q};
            SEL_MTIMECMP: data_read_clint = mtimecmp_q;
            SEL_MTIME:    data_read_clint = mtime_q;
            default:      data_read_clint = 64'd0;
        endcase
    end

    // Register file and interrupt flops; reset wins over a concurrent store.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
        end
    end

    assign mtip_o = mtip_q;
    assign msip_o = msip_q;

endmodule

// File: tb/tb_ysyx_22040632_clint.sv
// tb_ysyx_22040632_clint
// Bench for the CLINT: one instance with TICK_DIV=1 and one with TICK_DIV=4
// share all inputs. A behavioural model tracks both instances from the
// register map rules; directed sequences pin the documented corner values.

`timescale 1ns/1ps

module tb_ysyx_22040632_clint;

    localparam logic [31:0] A_MSIP  = 32'h0200_0000;
    localparam logic [31:0] A_CMP   = 32'h0200_4000;
    localparam logic [31:0] A_MTIME = 32'h0200_BFF8;
    localparam logic [31:0] A_UNM   = 32'h0200_8000;
    localparam logic [63:0] ALL1    = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic        wen;
        logic [31:0] waddr;
        logic [63:0] wdata;
        logic [31:0] raddr;
        logic [63:0] exp_rd;
        logic        exp_msip;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rd1;
    logic [63:0] rd4;
    logic        mtip1;
    logic        mtip4;
    logic        msip1;
    logic        msip4;

    int checks;
    int errors;

    logic [63:0] m_time [2];
    logic [63:0] m_cmp  [2];
    logic        m_msip [2];
    logic        m_mtip [2];
    int unsigned m_cnt  [2];
    int unsigned m_div  [2];

    vec_t        vecs [12];
    logic [31:0] raddr;
    logic [31:0] rnd_addr;
    logic [63:0] rnd_data;

    ysyx_22040632_clint #(
        .TICK_DIV   (1),
        .CLINT_BASE (32'h0200_0000)
    ) dut1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .wen_clint        (wen),
        .addr_clint       (addr),
        .data_write_clint (wdata),
        .data_read_clint  (rd1),
        .mtip_o           (mtip1),
        .msip_o           (msip1)
    );

    ysyx_22040632_clint #(
        .TICK_DIV   (4),
        .CLINT_BASE (32'h0200_0000)
    ) dut4 (
        .clk              (clk),
        .rst_n            (rst_n),
        .wen_clint        (wen),
        .addr_clint       (addr),
        .data_write_clint (wdata),
        .data_read_clint  (rd4),
        .mtip_o           (mtip4),
        .msip_o           (msip4)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Which register a byte address lands on: 1 msip, 2 mtimecmp, 3 mtime, 0 none.
    function automatic int region(input logic [31:0] a);
        logic [31:0] aligned;
        aligned = a & 32'hFFFF_FFF8;
        if (aligned == A_MSIP)  return 1;
        if (aligned == A_CMP)   return 2;
        if (aligned == A_MTIME) return 3;
        return 0;
    endfunction

    function automatic logic [63:0] modelRead(input int k, input logic [31:0] a);
        case (region(a))
            1:       return {63'd0, m_msip[k]};
            2:       return m_cmp[k];
            3:       return m_time[k];
            default: return 64'd0;
        endcase
    endfunction

    // Advance both models across one rising edge using the inputs now driven,
    // then let the edge happen and settle 1 ns past it.
    task automatic advance();
        logic [63:0] nt [2];
        logic [63:0] nc [2];
        logic        ns [2];
        logic        nm [2];
        logic        was_rst;
        int          r;
        r       = region(addr);
        was_rst = !rst_n;
        for (int k = 0; k < 2; k++) begin
            if (was_rst) begin
                nt[k] = 64'd0;
                nc[k] = ALL1;
                ns[k] = 1'b0;
                nm[k] = 1'b0;
            end else begin
                nm[k] = (m_time[k] >= m_cmp[k]);
                nt[k] = m_time[k];
                if (wen && r == 3) begin
                    nt[k] = wdata;
                end else if ((m_cnt[k] % m_div[k]) == m_div[k] - 1) begin
                    nt[k] = m_time[k] + 64'd1;
                end
                nc[k] = (wen && r == 2) ? wdata : m_cmp[k];
                ns[k] = (wen && r == 1) ? wdata[0] : m_msip[k];
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_time[k] = nt[k];
            m_cmp[k]  = nc[k];
            m_msip[k] = ns[k];
            m_mtip[k] = nm[k];
            m_cnt[k]  = was_rst ? 0 : m_cnt[k] + 1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                                 input logic [63:0] d);
        rst_n = r;
        wen   = w;
        addr  = a;
        wdata = d;
        advance();
    endtask

    // Move the load address without an edge and let the read path settle.
    task automatic peek(input logic [31:0] a);
        wen  = 1'b0;
        addr = a;
        #1;
    endtask

    task automatic checkValue(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every output of both instances against the model at the
    // address currently presented.
    task automatic checkOutput(input string name);
        checkValue({name, "/rd1"},   rd1,          modelRead(0, addr));
        checkValue({name, "/rd4"},   rd4,          modelRead(1, addr));
        checkValue({name, "/mtip1"}, {63'd0, mtip1}, {63'd0, m_mtip[0]});
        checkValue({name, "/mtip4"}, {63'd0, mtip4}, {63'd0, m_mtip[1]});
        checkValue({name, "/msip1"}, {63'd0, msip1}, {63'd0, m_msip[0]});
        checkValue({name, "/msip4"}, {63'd0, msip4}, {63'd0, m_msip[1]});
    endtask

    // Main test sequence.
    initial begin
        checks   = 0;
        errors   = 0;
        m_div[0] = 1;
        m_div[1] = 4;
        for (int k = 0; k < 2; k++) begin
            m_time[k] = 64'd0;
            m_cmp[k]  = ALL1;
            m_msip[k] = 1'b0;
            m_mtip[k] = 1'b0;
            m_cnt[k]  = 0;
        end
        rst_n = 1'b0;
        wen   = 1'b0;
        addr  = A_MSIP;
        wdata = 64'd0;

        vecs[0]  = '{1'b1, A_MSIP,                ALL1,          A_MSIP,                64'd1,       1'b1};
        vecs[1]  = '{1'b0, A_MSIP,                64'd0,         A_MSIP,                64'd1,       1'b1};
        vecs[2]  = '{1'b1, A_MSIP,                64'd0,         A_MSIP,                64'd0,       1'b0};
        vecs[3]  = '{1'b1, A_MSIP,                64'h3,         A_UNM,                 64'd0,       1'b1};
        vecs[4]  = '{1'b1, A_UNM,                 64'hDEAD,      A_UNM,                 64'd0,       1'b1};
        vecs[5]  = '{1'b1, A_MSIP + 32'd4,        64'h2,         A_MSIP,                64'd0,       1'b0};
        vecs[6]  = '{1'b1, A_CMP + 32'd5,         64'h1234,      A_CMP,                 64'h1234,    1'b0};
        vecs[7]  = '{1'b1, A_UNM,                 64'hDEAD,      A_CMP,                 64'h1234,    1'b0};
        vecs[8]  = '{1'b1, 32'h01FF_FFF8,         64'd0,         A_CMP,                 64'h1234,    1'b0};
        vecs[9]  = '{1'b1, 32'h0201_4000,         64'd0,         A_CMP,                 64'h1234,    1'b0};
        vecs[10] = '{1'b1, 32'h0201_4000,         64'd5,         32'h0201_4000,         64'd0,       1'b0};
        vecs[11] = '{1'b1, A_MSIP,                64'd1,         A_CMP + 32'd7,         64'h1234,    1'b1};

        // Reset with a store pending: the store must not land.
        applyStimulus(1'b0, 1'b1, A_MTIME, 64'hDEAD);
        applyStimulus(1'b0, 1'b1, A_CMP, 64'd7);
        peek(A_MTIME);
        checkValue("rst_mtime1", rd1, 64'd0);
        checkValue("rst_mtime4", rd4, 64'd0);
        peek(A_CMP);
        checkValue("rst_cmp1", rd1, ALL1);
        peek(A_MSIP);
        checkValue("rst_msip1", rd1, 64'd0);
        checkValue("rst_mtip1", {63'd0, mtip1}, 64'd0);
        checkValue("rst_msipo1", {63'd0, msip1}, 64'd0);
        checkOutput("rst");

        // Prescaler: 12 edges after release give mtime 3 at TICK_DIV=4.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0, A_MTIME, 64'd0);
        end
        peek(A_MTIME);
        checkValue("div4_12cyc", rd4, 64'd3);
        checkValue("div1_12cyc", rd1, 64'd12);
        applyStimulus(1'b1, 1'b0, A_MTIME, 64'd0);
        applyStimulus(1'b1, 1'b1, A_MTIME, 64'd100);
        checkValue("div4_wr100", rd4, 64'd100);
        checkOutput("wr100");
        applyStimulus(1'b1, 1'b0, A_MTIME, 64'd0);
        checkValue("div4_hold100", rd4, 64'd100);
        applyStimulus(1'b1, 1'b0, A_MTIME, 64'd0);
        checkValue("div4_tick101", rd4, 64'd101);
        checkOutput("tick101");

        // Timer interrupt raise and clear at TICK_DIV=1.
        applyStimulus(1'b1, 1'b1, A_MTIME, 64'd5);
        applyStimulus(1'b1, 1'b1, A_CMP, 64'd10);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, A_MTIME, 64'd0);
        end
        checkValue("mtime_at10", rd1, 64'd10);
        checkValue("mtip_not_yet", {63'd0, mtip1}, 64'd0);
        applyStimulus(1'b1, 1'b0, A_MTIME, 64'd0);
        checkValue("mtip_rise", {63'd0, mtip1}, 64'd1);
        checkOutput("mtip_rise");
        applyStimulus(1'b1, 1'b1, A_CMP, ALL1);
        checkValue("mtip_still", {63'd0, mtip1}, 64'd1);
        applyStimulus(1'b1, 1'b0, A_CMP, 64'd0);
        checkValue("mtip_clear", {63'd0, mtip1}, 64'd0);
        checkOutput("mtip_clear");

        // mtime wrap: mtip high for exactly one cycle.
        applyStimulus(1'b1, 1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus(1'b1, 1'b1, A_CMP, ALL1);
        peek(A_MTIME);
        checkValue("wrap_ffff", rd1, ALL1);
        checkValue("wrap_mtip0", {63'd0, mtip1}, 64'd0);
        applyStimulus(1'b1, 1'b0, A_MTIME, 64'd0);
        checkValue("wrap_zero", rd1, 64'd0);
        checkValue("wrap_mtip1", {63'd0, mtip1}, 64'd1);
        checkOutput("wrap");
        applyStimulus(1'b1, 1'b0, A_MTIME, 64'd0);
        checkValue("wrap_mtip_drop", {63'd0, mtip1}, 64'd0);
        applyStimulus(1'b1, 1'b0, A_MTIME, 64'd0);
        checkValue("wrap_mtip_low", {63'd0, mtip1}, 64'd0);

        // msip and unmapped-address vectors.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, vecs[i].wen, vecs[i].waddr, vecs[i].wdata);
            peek(vecs[i].raddr);
            checkValue($sformatf("vec%0d_rd1", i), rd1, vecs[i].exp_rd);
            checkValue($sformatf("vec%0d_rd4", i), rd4, vecs[i].exp_rd);
            checkValue($sformatf("vec%0d_msip1", i), {63'd0, msip1}, {63'd0, vecs[i].exp_msip});
            checkValue($sformatf("vec%0d_msip4", i), {63'd0, msip4}, {63'd0, vecs[i].exp_msip});
            checkOutput($sformatf("vec%0d", i));
        end
        peek(A_MTIME);
        checkOutput("vec_mtime");

        // Randomized traffic with occasional resets, checked against the model.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0:       rnd_addr = A_MSIP | 32'($urandom_range(0, 7));
                1:       rnd_addr = A_CMP | 32'($urandom_range(0, 7));
                2:       rnd_addr = A_MTIME | 32'($urandom_range(0, 7));
                3:       rnd_addr = A_UNM;
                4:       rnd_addr = 32'h0200_0000 + ($urandom & 32'h0000_FFF8);
                default: rnd_addr = $urandom;
            endcase
            if ($urandom_range(0, 1) == 0) begin
                rnd_data = {$urandom, $urandom};
            end else begin
                rnd_data = 64'($urandom_range(0, 40));
            end
            applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
                          rnd_addr, rnd_data);
            case ($urandom_range(0, 3))
                0:       raddr = A_MSIP;
                1:       raddr = A_CMP;
                2:       raddr = A_MTIME;
                default: raddr = $urandom;
            endcase
            peek(raddr);
            checkOutput($sformatf("rand%0d", i));
        end

        // Reset mid-count with stores pending, then first increment timing.
        applyStimulus(1'b1, 1'b1, A_MSIP, 64'd1);
        applyStimulus(1'b0, 1'b1, A_CMP, 64'd5);
        applyStimulus(1'b0, 1'b1, A_MSIP, 64'd1);
        peek(A_CMP);
        checkValue("rstw_cmp", rd1, ALL1);
        peek(A_MSIP);
        checkValue("rstw_msip", rd4, 64'd0);
        checkValue("rstw_msipo", {63'd0, msip4}, 64'd0);
        checkValue("rstw_mtip", {63'd0, mtip4}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, A_MTIME, 64'd0);
        end
        checkValue("first_inc_before", rd4, 64'd0);
        applyStimulus(1'b1, 1'b0, A_MTIME, 64'd0);
        checkValue("first_inc_at4", rd4, 64'd1);
        checkOutput("first_inc");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
